// File: rtl/crc_frame_tx.sv
// crc_frame_tx: buffers a 1..MAX_BYTES byte payload, then sends start strobe, payload bits and CRC-16 MSB-first
// Ports: clock/reset (sync, active high); go+len start a frame from IDLE; din/din_valid/din_ready load payload bytes;
//        tx_start/tx_data serial output; busy outside IDLE; done pulses after the last CRC bit; crc holds the last frame CRC
module crc_frame_tx #(
  parameter int MAX_BYTES = 16,
  parameter logic [15:0] POLY = 16'h8005,
  parameter logic [15:0] INIT = 16'h0000,
  localparam int LW = $clog2(MAX_BYTES + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          go,
  input  logic [LW-1:0] len,
  input  logic [7:0]    din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          tx_start,
  output logic          tx_data,
  output logic          busy,
  output logic          done,
  output logic [15:0]   crc
);
  localparam int AW = MAX_BYTES > 1 ? $clog2(MAX_BYTES) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, START, PAYLOAD, CRCOUT, DONE} state_t;
  state_t state;
  logic [7:0] mem [MAX_BYTES];
  logic [LW-1:0] len_r, cnt, nxt;
  logic [2:0] bit_idx;
  logic [3:0] crc_cnt;
  logic [15:0] crc_reg, crc_next;
  logic next_bit, last_bit;
  // cnt is the load count in LOAD and the byte index while serialising
  always_comb begin
    nxt = cnt + 1'b1;
    last_bit = nxt == len_r && bit_idx == 3'd7;
    next_bit = bit_idx == 3'd7 ? mem[nxt[AW-1:0]][7] : mem[cnt[AW-1:0]][3'(3'd6 - bit_idx)];
    crc_next = {crc_reg[14:0], 1'b0} ^ ((crc_reg[15] ^ tx_data) ? POLY : 16'h0000);
  end
  always_ff @(posedge clock)
    if (state == LOAD && din_valid) mem[cnt[AW-1:0]] <= din;
  // tx_data is registered one step ahead so it already holds the bit of the current cycle,
  // which is also the bit folded into the CRC at the end of that cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      len_r <= '0;
      cnt <= '0;
      bit_idx <= '0;
      crc_cnt <= '0;
      crc_reg <= '0;
      crc <= '0;
      din_ready <= 1'b0;
      tx_start <= 1'b0;
      tx_data <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (go && len != '0 && len <= LW'(MAX_BYTES)) begin
          len_r <= len;
          cnt <= '0;
          crc_reg <= INIT;
          crc <= '0;
          state <= LOAD;
          din_ready <= 1'b1;
          busy <= 1'b1;
        end
        LOAD: if (din_valid) begin
          cnt <= nxt;
          if (nxt == len_r) begin
            state <= START;
            din_ready <= 1'b0;
            tx_start <= 1'b1;
          end
        end
        START: begin
          state <= PAYLOAD;
          cnt <= '0;
          bit_idx <= '0;
          tx_data <= mem[AW'(0)][7];
        end
        PAYLOAD: begin
          crc_reg <= crc_next;
          if (last_bit) begin
            crc <= crc_next;
            crc_cnt <= '0;
            tx_data <= crc_next[15];
            state <= CRCOUT;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) cnt <= nxt;
            tx_data <= next_bit;
          end
        end
        CRCOUT: if (crc_cnt == 4'd15) begin
          state <= DONE;
          done <= 1'b1;
          tx_data <= 1'b0;
        end else begin
          crc_cnt <= crc_cnt + 1'b1;
          tx_data <= crc[4'(4'd14 - crc_cnt)];
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_frame_tx.sv
// tb_crc_frame_tx: directed and random frames checked against a polynomial long-division model
module tb_crc_frame_tx;
  localparam logic [15:0] POLY = 16'h8005;
  logic clock = 1'b0, reset = 1'b1, go = 1'b0, din_valid = 1'b0;
  logic [4:0] len = '0;
  logic [7:0] din = '0;
  logic din_ready, tx_start, tx_data, busy, done;
  logic [15:0] crc;
  int checks = 0, passed = 0;
  logic [7:0] pay[$];
  crc_frame_tx dut (.clock(clock), .reset(reset), .go(go), .len(len), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .done(done), .crc(crc));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  // remainder of (message * x^16) mod P, by long division over a bit list
  function automatic logic [15:0] crc_of(input bit q[$]);
    bit m[$];
    logic [16:0] p;
    logic [15:0] r;
    p = {1'b1, POLY};
    m = q;
    for (int i = 0; i < 16; i++) m.push_back(1'b0);
    for (int i = 0; i < q.size(); i++)
      if (m[i]) for (int k = 0; k < 17; k++) m[i+k] = m[i+k] ^ p[16-k];
    for (int i = 0; i < 16; i++) r[15-i] = m[q.size()+i];
    return r;
  endfunction
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic run_frame(input logic [15:0] gap_mask, input int go_at, input int abort_at);
    int n, rdy, ngap;
    bit bits[$], obs[$];
    logic [15:0] exp_crc;
    n = pay.size();
    rdy = 0;
    ngap = 0;
    foreach (pay[i]) for (int b = 7; b >= 0; b--) bits.push_back(pay[i][b]);
    exp_crc = crc_of(bits);
    for (int b = 15; b >= 0; b--) bits.push_back(exp_crc[b]);
    go = 1'b1;
    len = 5'(n);
    tick();
    go = 1'b0;
    chk("load_busy", busy, 1);
    chk("crc_cleared", crc, 0);
    for (int i = 0; i < n; i++) begin
      if (gap_mask[i]) begin
        din_valid = 1'b0;
        rdy += int'(din_ready);
        ngap++;
        tick();
      end
      din_valid = 1'b1;
      din = pay[i];
      rdy += int'(din_ready);
      tick();
    end
    din_valid = 1'b0;
    chk("ready_cycles", rdy, n + ngap);
    chk("tx_start", tx_start, 1);
    chk("start_data", tx_data, 0);
    chk("start_ready", din_ready, 0);
    for (int k = 0; k < bits.size(); k++) begin
      go = 1'b0;
      tick();
      if (tx_data !== bits[k] || tx_start !== 1'b0 || done !== 1'b0) chk($sformatf("bit%0d", k), {done, tx_start, tx_data}, {2'b00, bits[k]});
      else begin checks++; passed++; end
      obs.push_back(tx_data);
      if (k == 8 * n) chk("crc_out", crc, exp_crc);
      if (k == go_at) begin
        go = 1'b1;
        len = 5'd3;
      end
      if (k == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_data", tx_data, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", din_ready, 0);
        return;
      end
    end
    go = 1'b0;
    tick();
    chk("done", done, 1);
    chk("done_busy", busy, 1);
    chk("done_data", tx_data, 0);
    tick();
    chk("done_low", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", din_ready, 0);
    chk("crc_hold", crc, exp_crc);
    chk("rx_remainder", crc_of(obs), 0);
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_ready", din_ready, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_crc", crc, 0);
    reset = 1'b0;
    tick();
    pay = '{8'h01};
    run_frame(16'h0, -1, -1);
    chk("crc_8005", crc, 16'h8005);
    pay = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h30, 8'h3A};
    run_frame(16'h0024, -1, -1);
    go = 1'b1;
    len = 5'd0;
    tick();
    go = 1'b0;
    chk("len0_busy", busy, 0);
    chk("len0_ready", din_ready, 0);
    go = 1'b1;
    len = 5'd17;
    tick();
    go = 1'b0;
    chk("len17_busy", busy, 0);
    chk("len17_ready", din_ready, 0);
    pay = '{8'hA5, 8'h5A};
    run_frame(16'h0, 5, -1);
    pay = '{8'hC3, 8'h7E, 8'h11};
    run_frame(16'h0, -1, 10);
    pay = '{8'h00};
    run_frame(16'h0, -1, -1);
    chk("zero_crc", crc, 0);
    pay = {};
    for (int i = 0; i < 16; i++) pay.push_back(8'hFF);
    run_frame(16'h0, -1, -1);
    for (int f = 0; f < 4; f++) begin
      pay = {};
      for (int i = 0; i < $urandom_range(1, 16); i++) pay.push_back(8'($urandom));
      run_frame(16'($urandom), -1, -1);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
